// File: rtl/eng_uc_port.sv
// eng_uc_port: engine-side unit-literal port with outbound (to arbiter) and inbound (broadcast) FIFOs.
// Optional macro UC_DEDUP_EN drops outbound pushes that duplicate an already queued literal.
`ifndef UC_LENGTH
`define UC_LENGTH 64
`endif

module eng_uc_port #(
   parameter int unsigned OUT_DEPTH = 8,
   parameter int unsigned IN_DEPTH  = 8,
   localparam int unsigned LW       = $clog2(`UC_LENGTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          eng_push,
   input  logic [LW-1:0] eng_lit,
   output logic          eng_full,
   input  logic          uca_grant,
   input  logic          uca2eng_pop,
   output logic [LW-1:0] eng2uca_min,
   output logic          eng2uca_valid,
   output logic          eng2uca_empty,
   input  logic          uca2eng_valid,
   input  logic [LW-1:0] uca2eng,
   output logic          uca2eng_full,
   input  logic          conflict,
   input  logic          eng_pop,
   output logic [LW-1:0] eng_in_lit,
   output logic          eng_in_empty,
   output logic          uc_ovf
);

   localparam int unsigned OPW = $clog2(OUT_DEPTH);
   localparam int unsigned IPW = $clog2(IN_DEPTH);
   localparam logic [OPW:0] OutCap = (OPW+1)'(OUT_DEPTH);
   localparam logic [IPW:0] InCap  = (IPW+1)'(IN_DEPTH);

   typedef enum logic {StRun, StFlush} state_e;

   state_e         r_state;
   logic [LW-1:0]  r_out_mem [OUT_DEPTH];
   logic [OPW-1:0] r_out_rd;
   logic [OPW-1:0] r_out_wr;
   logic [OPW:0]   r_out_cnt;
   logic [LW-1:0]  r_in_mem [IN_DEPTH];
   logic [IPW-1:0] r_in_rd;
   logic [IPW-1:0] r_in_wr;
   logic [IPW:0]   r_in_cnt;
   logic           r_ovf;

   logic w_run;
   logic w_out_empty;
   logic w_out_full;
   logic w_out_pop;
   logic w_out_push;
   logic w_out_dup;
   logic w_in_empty;
   logic w_in_full;
   logic w_in_pop;
   logic w_in_offer;
   logic w_in_wr;
   logic w_in_ovf;

   // A conflict in the same cycle overrides every other request.
   assign w_run       = (r_state == StRun) && !conflict;

   assign w_out_empty = (r_out_cnt == '0);
   assign w_out_full  = (r_out_cnt == OutCap);
   assign w_out_pop   = w_run && uca2eng_pop && uca_grant && !w_out_empty;
   assign w_out_push  = w_run && eng_push && (eng_lit != '0) && !w_out_dup &&
                        (!w_out_full || w_out_pop);

`ifdef UC_DEDUP_EN
   always_comb begin
      w_out_dup = 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
         if (({1'b0, OPW'(i) - r_out_rd} < r_out_cnt) && (r_out_mem[i] == eng_lit)) begin
            w_out_dup = 1'b1;
         end
      end
   end
`else
   assign w_out_dup = 1'b0;
`endif

   assign w_in_empty = (r_in_cnt == '0);
   assign w_in_full  = (r_in_cnt == InCap);
   assign w_in_pop   = w_run && eng_pop && !w_in_empty;
   assign w_in_offer = w_run && uca2eng_valid && (uca2eng != '0);
   assign w_in_wr    = w_in_offer && (!w_in_full || w_in_pop);
   assign w_in_ovf   = w_in_offer && w_in_full && !w_in_pop;

   assign eng_full      = w_out_full || (r_state == StFlush);
   assign eng2uca_min   = w_out_empty ? '0 : r_out_mem[r_out_rd];
   assign eng2uca_valid = !w_out_empty;
   assign eng2uca_empty = w_out_empty;
   assign uca2eng_full  = w_in_full || (r_state == StFlush);
   assign eng_in_lit    = w_in_empty ? '0 : r_in_mem[r_in_rd];
   assign eng_in_empty  = w_in_empty;
   assign uc_ovf        = r_ovf;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= StRun;
         r_out_rd  <= '0;
         r_out_wr  <= '0;
         r_out_cnt <= '0;
         r_in_rd   <= '0;
         r_in_wr   <= '0;
         r_in_cnt  <= '0;
         r_ovf     <= 1'b0;
      end else if (conflict) begin
         r_state   <= StFlush;
         r_out_rd  <= '0;
         r_out_wr  <= '0;
         r_out_cnt <= '0;
         r_in_rd   <= '0;
         r_in_wr   <= '0;
         r_in_cnt  <= '0;
         r_ovf     <= 1'b0;
      end else if (r_state == StFlush) begin
         r_state <= StRun;
      end else begin
         if (w_out_push) r_out_wr <= r_out_wr + 1'b1;
         if (w_out_pop)  r_out_rd <= r_out_rd + 1'b1;
         if (w_out_push && !w_out_pop) begin
            r_out_cnt <= r_out_cnt + 1'b1;
         end else if (!w_out_push && w_out_pop) begin
            r_out_cnt <= r_out_cnt - 1'b1;
         end
         if (w_in_wr)  r_in_wr <= r_in_wr + 1'b1;
         if (w_in_pop) r_in_rd <= r_in_rd + 1'b1;
         if (w_in_wr && !w_in_pop) begin
            r_in_cnt <= r_in_cnt + 1'b1;
         end else if (!w_in_wr && w_in_pop) begin
            r_in_cnt <= r_in_cnt - 1'b1;
         end
         if (w_in_ovf) r_ovf <= 1'b1;
      end
   end

   // Storage needs no reset: outputs are masked whenever the count says empty.
   always_ff @(posedge clk) begin
      if (w_out_push) r_out_mem[r_out_wr] <= eng_lit;
      if (w_in_wr)    r_in_mem[r_in_wr]   <= uca2eng;
   end

endmodule

// File: doc/eng_uc_port.md
ENG_UC_PORT -- requirements
Module: eng_uc_port

Interface
REQ-001 SHALL have parameter OUT_DEPTH, default 8, outbound unit-literal FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter IN_DEPTH, default 8, inbound broadcast FIFO entries (power of 2, >=2).
REQ-003 SHALL define LW = $clog2(`UC_LENGTH); all literals signed LW bits, value 0 = no literal.
REQ-004 SHALL have ports:
 clk  in  1  sole clock, rising edge;
 rst  in  1  asynchronous, active-low reset;
 eng_push  in  1  engine offers implied literal;
 eng_lit  in  LW  literal offered with eng_push;
 eng_full  out  1  outbound FIFO cannot accept;
 uca_grant  in  1  arbiter currently selects this engine;
 uca2eng_pop  in  1  arbiter consumes selected head;
 eng2uca_min  out  LW  outbound head literal;
 eng2uca_valid  out  1  head literal valid;
 eng2uca_empty  out  1  outbound FIFO empty;
 uca2eng_valid  in  1  broadcast literal present;
 uca2eng  in  LW  broadcast literal;
 uca2eng_full  out  1  inbound FIFO cannot accept;
 conflict  in  1  global conflict, flush request;
 eng_pop  in  1  engine consumes inbound head;
 eng_in_lit  out  LW  inbound head literal;
 eng_in_empty  out  1  inbound FIFO empty;
 uc_ovf  out  1  sticky inbound-overflow flag.

Function
REQ-005 Outbound: push accepted when eng_push=1, eng_lit!=0, state RUN, and (not full or effective pop same cycle); else dropped silently.
REQ-006 Effective outbound pop = uca2eng_pop & uca_grant & !eng2uca_empty; pop without grant or when empty SHALL be ignored.
REQ-007 eng2uca_min = head entry, 0 when empty; eng2uca_valid = !eng2uca_empty; all combinational from registered state.
REQ-008 Push-to-visible latency SHALL be 1 cycle; pop removes head at the clock edge, next entry visible following cycle.
REQ-009 Occupancy counters SHALL span 0..DEPTH inclusive; pointers wrap modulo DEPTH.
REQ-010 eng_full = (count==OUT_DEPTH) or state FLUSH; uca2eng_full = (count==IN_DEPTH) or state FLUSH.
REQ-011 Inbound: broadcast with uca2eng_valid=1, uca2eng!=0, state RUN is written if not full or eng_pop effective same cycle; written 1 cycle later visible on eng_in_lit.
REQ-012 Broadcast arriving when inbound full (no concurrent pop) SHALL be dropped and set uc_ovf=1.
REQ-013 eng_pop ignored when eng_in_empty=1; eng_in_lit = 0 when empty.
REQ-014 FSM states RUN, FLUSH; RUN->FLUSH when conflict=1; FLUSH->RUN after exactly one cycle unless conflict still 1.
REQ-015 Entering FLUSH SHALL clear both FIFOs and uc_ovf at that edge; pushes, pops, broadcasts during FLUSH ignored.
REQ-016 conflict takes priority over every simultaneous push, pop or broadcast in the same cycle.

Reset
REQ-017 rst=0 SHALL asynchronously force state RUN, both FIFOs empty, pointers 0, uc_ovf=0.
REQ-018 Outputs under reset: eng_full=0, eng2uca_min=0, eng2uca_valid=0, eng2uca_empty=1, uca2eng_full=0, eng_in_lit=0, eng_in_empty=1, uc_ovf=0.
REQ-019 Reset asserted mid-operation SHALL discard all queued literals; no partial state survives.

Configuration
REQ-020 Macro UC_DEDUP_EN defined: outbound push whose eng_lit equals any occupied outbound entry SHALL be dropped (no write, no count change).
REQ-021 UC_DEDUP_EN undefined: duplicates accepted like any other literal; no comparator logic present.

Verification
REQ-022 Reset, push 5,-3,7; grant=1, pop x3 -> eng2uca_min 5,-3,7 on successive cycles, then empty=1, min=0.
REQ-023 Fill OUT_DEPTH=8 -> eng_full=1; push 9 with granted pop same cycle -> accepted, count stays 8, 9 last out.
REQ-024 uca2eng_pop=1, uca_grant=0 with head 4 -> head stays 4, count unchanged.
REQ-025 Fill inbound with 8 broadcasts, send 11 -> dropped, uc_ovf=1; conflict pulse -> both empty, uc_ovf=0, full flags 1 for one cycle, then 0.
REQ-026 With UC_DEDUP_EN: push 6,6,-6 -> entries 6,-6 only; without: 6,6,-6.
REQ-027 Drive rst=0 asynchronously mid-burst with 3 queued -> outputs reach REQ-018 values before next clock edge.
